// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// MDU latencies and the IDLE/BUSY encoding live here so every file agrees on them.
package pipe_ctrl_pkg;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int MD_CNT_W    = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef logic [MD_CNT_W-1:0] md_cnt_t;

    function automatic md_cnt_t md_load_value(input logic is_div);
        return is_div ? md_cnt_t'(DIV_CYCLES) : md_cnt_t'(MULT_CYCLES);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/exception signal bundle between the datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;

    logic        req;
    logic        stall_raw;
    logic        md_start;
    logic        md_is_div;
    logic        md_use_D;
    logic        eret_D;
    logic        epc_wr_pending;
    logic        pc_en;
    logic        D_en;
    logic        E_clr;
    logic        flush_all;
    logic        md_busy;
    logic        md_state;
    logic [31:0] stall_cycles;

    modport master (
        output req, stall_raw, md_start, md_is_div, md_use_D, eret_D, epc_wr_pending,
        input  pc_en, D_en, E_clr, flush_all, md_busy, md_state, stall_cycles
    );

    modport slave (
        input  req, stall_raw, md_start, md_is_div, md_use_D, eret_D, epc_wr_pending,
        output pc_en, D_en, E_clr, flush_all, md_busy, md_state, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_mdu_timer.sv
// Multiply/divide latency timer: a down-counter loaded on an accepted MDU start,
// busy while nonzero. A start coinciding with abort (exception) is dropped.
module mdu_timer
    import pipe_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      start,
    input  logic      is_div,
    input  logic      abort,
    output logic      busy,
    output md_state_t state
);

    md_cnt_t cnt;
    md_cnt_t cnt_next;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

    // Starts are only accepted from idle; a running op counts down to zero and stops.
    always_comb begin
        cnt_next = cnt;
        if (start && !abort && (cnt == '0))
            cnt_next = md_load_value(is_div);
        else if (cnt != '0)
            cnt_next = cnt - 1'b1;
    end

    always_comb begin
        busy  = (cnt != '0);
        state = busy ? MD_BUSY : MD_IDLE;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges RAW, MDU and eret hazards, gives exceptions priority.
// Optional bubble-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    logic      stall;
    logic      md_busy;
    logic      e_clr;
    md_state_t md_state;

    mdu_timer u_mdu_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.md_start),
        .is_div (bus.md_is_div),
        .abort  (bus.req),
        .busy   (md_busy),
        .state  (md_state)
    );

    // The eret term holds D until the mtc0 EPC write has drained out of E/M.
    always_comb begin
        stall = bus.stall_raw
              | (bus.md_use_D & (md_busy | bus.md_start))
              | (bus.eret_D & bus.epc_wr_pending);
        e_clr = stall & ~bus.req;
    end

    assign bus.flush_all = bus.req;
    assign bus.pc_en     = ~stall | bus.req;
    assign bus.D_en      = ~stall | bus.req;
    assign bus.E_clr     = e_clr;
    assign bus.md_busy   = md_busy;
    assign bus.md_state  = logic'(md_state);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Saturates rather than wrapping so long runs never report a small count.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (e_clr && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule
